// File: rtl/register_bank_banked.sv
// Dual-bank register file with two combinational read ports, one write port,
// optional write-to-read bypass, optional hard-wired zero register, a bank
// swap for fast context switches and a sequential clear engine that zeroes
// the active bank one register per cycle.
module register_bank_banked #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_write_en,
  input  logic [ADDR_WIDTH-1:0] in_write_selector,
  input  logic [DATA_WIDTH-1:0] in_write_data,
  input  logic [ADDR_WIDTH-1:0] in_rx_selector,
  input  logic [ADDR_WIDTH-1:0] in_ry_selector,
  output logic [DATA_WIDTH-1:0] out_rx_data,
  output logic [DATA_WIDTH-1:0] out_ry_data,
  input  logic                  in_bank_swap,
  output logic                  out_active_bank,
  input  logic                  in_clear_req,
  output logic                  out_busy,
  output logic                  out_clear_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] regs [2][DEPTH];
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic idle;
  logic write_ok;
  logic swap_ok;
  logic bypass_ok;

  assign idle      = (state == IDLE);
  // Writes to the zero register are dropped so it keeps its reset value.
  assign write_ok  = in_write_en && idle &&
                     !(ZERO_REG && (in_write_selector == '0));
  // A clear request in the same cycle wins and the swap is lost.
  assign swap_ok   = in_bank_swap && idle && !in_clear_req;
  assign bypass_ok = BYPASS && in_write_en && idle;

  // Next-state logic: one pass through all DEPTH registers per clear request.
  always_comb begin
    // NOTE: assign every always_comb output a default first; a path that
    // leaves it unassigned would infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (in_clear_req) state_next = CLEAR;
      CLEAR:   if (clr_cnt == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered busy flag and clear-complete pulse.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state          <= IDLE;
      out_busy       <= 1'b0;
      out_clear_done <= 1'b0;
    end else begin
      state          <= state_next;
      out_busy       <= (state_next == CLEAR);
      out_clear_done <= (state == CLEAR) && (state_next == IDLE);
    end
  end

  // Clear address counter: restarts on entry, advances once per clear beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt <= '0;
    end else if (idle && in_clear_req) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Active bank selector, toggled only by an accepted swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_active_bank <= 1'b0;
    end else if (swap_ok) begin
      out_active_bank <= ~out_active_bank;
    end
  end

  // Register storage: clear beats take priority; writes target the bank that
  // is active before any same-cycle swap takes effect.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: this array is built from flops and must come up zeroed, so it is
    // reset explicitly; a RAM macro could not be reset like this.
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          regs[b][i] <= '0;
        end
      end
    end else if (state == CLEAR) begin
      regs[out_active_bank][clr_cnt] <= '0;
    end else if (write_ok) begin
      regs[out_active_bank][in_write_selector] <= in_write_data;
    end
  end

  // Read port X: array contents, optionally forwarded write data, zero reg.
  always_comb begin
    out_rx_data = regs[out_active_bank][in_rx_selector];
    if (bypass_ok && (in_rx_selector == in_write_selector)) begin
      out_rx_data = in_write_data;
    end
    if (ZERO_REG && (in_rx_selector == '0)) begin
      out_rx_data = '0;
    end
  end

  // Read port Y: same selection rules as port X.
  always_comb begin
    out_ry_data = regs[out_active_bank][in_ry_selector];
    if (bypass_ok && (in_ry_selector == in_write_selector)) begin
      out_ry_data = in_write_data;
    end
    if (ZERO_REG && (in_ry_selector == '0)) begin
      out_ry_data = '0;
    end
  end

endmodule

// File: tb/tb_register_bank_banked.sv
// Directed bench for register_bank_banked: a vector table for reads, writes,
// bypass and swaps, then hand sequences for clear, reset mid-clear,
// clear-versus-swap and a 16-bit / 16-deep zero-register instance.
module tb_register_bank_banked;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic       a_we, a_swap, a_clr;
  logic [2:0] a_wsel, a_rx, a_ry;
  logic [7:0] a_wd, a_rx_d, a_ry_d;
  logic       a_bank, a_busy, a_done;

  // Instance B: 16-bit, 16 registers, zero register enabled.
  logic        b_we, b_swap, b_clr;
  logic [3:0]  b_wsel, b_rx, b_ry;
  logic [15:0] b_wd, b_rx_d, b_ry_d;
  logic        b_bank, b_busy, b_done;

  register_bank_banked dut_a (
    .clk(clk), .reset(reset),
    .in_write_en(a_we), .in_write_selector(a_wsel), .in_write_data(a_wd),
    .in_rx_selector(a_rx), .in_ry_selector(a_ry),
    .out_rx_data(a_rx_d), .out_ry_data(a_ry_d),
    .in_bank_swap(a_swap), .out_active_bank(a_bank),
    .in_clear_req(a_clr), .out_busy(a_busy), .out_clear_done(a_done)
  );

  register_bank_banked #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .BYPASS(1'b1), .ZERO_REG(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset),
    .in_write_en(b_we), .in_write_selector(b_wsel), .in_write_data(b_wd),
    .in_rx_selector(b_rx), .in_ry_selector(b_ry),
    .out_rx_data(b_rx_d), .out_ry_data(b_ry_d),
    .in_bank_swap(b_swap), .out_active_bank(b_bank),
    .in_clear_req(b_clr), .out_busy(b_busy), .out_clear_done(b_done)
  );

  typedef struct {
    logic       we;
    logic [2:0] wsel;
    logic [7:0] wd;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       swap;
    logic [7:0] exp_rx;
    logic [7:0] exp_ry;
    logic       exp_bank;
  } vec_t;

  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] wsel,
                              input logic [7:0] wd, input logic [2:0] rx,
                              input logic [2:0] ry, input logic swap,
                              input logic [7:0] exp_rx, input logic [7:0] exp_ry,
                              input logic exp_bank);
    vec_t v;
    v.we = we; v.wsel = wsel; v.wd = wd; v.rx = rx; v.ry = ry; v.swap = swap;
    v.exp_rx = exp_rx; v.exp_ry = exp_ry; v.exp_bank = exp_bank;
    return v;
  endfunction

  task automatic set_a(input logic we, input logic [2:0] wsel,
                       input logic [7:0] wd, input logic [2:0] rx,
                       input logic [2:0] ry, input logic swap, input logic clr);
    a_we = we; a_wsel = wsel; a_wd = wd; a_rx = rx; a_ry = ry;
    a_swap = swap; a_clr = clr;
  endtask

  task automatic set_b(input logic we, input logic [3:0] wsel,
                       input logic [15:0] wd, input logic [3:0] rx,
                       input logic [3:0] ry, input logic clr);
    b_we = we; b_wsel = wsel; b_wd = wd; b_rx = rx; b_ry = ry;
    b_swap = 1'b0; b_clr = clr;
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, last_busy;
    bit seen;

    set_a(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
    set_b(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0);

    // Test 1 and 2 vectors: bypass, stored reads, swaps, swap+write.
    vecs[0]  = mk(1'b1, 3'd3, 8'hA5, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    vecs[1]  = mk(1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 1'b0, 8'hA5, 8'hA5, 1'b0);
    vecs[2]  = mk(1'b1, 3'd5, 8'h3C, 3'd5, 3'd3, 1'b0, 8'h3C, 8'hA5, 1'b0);
    vecs[3]  = mk(1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 1'b0, 8'h3C, 8'hA5, 1'b0);
    vecs[4]  = mk(1'b1, 3'd1, 8'h11, 3'd1, 3'd5, 1'b0, 8'h11, 8'h3C, 1'b0);
    vecs[5]  = mk(1'b0, 3'd0, 8'h00, 3'd1, 3'd1, 1'b1, 8'h11, 8'h11, 1'b0);
    vecs[6]  = mk(1'b1, 3'd1, 8'h22, 3'd1, 3'd3, 1'b0, 8'h22, 8'h00, 1'b1);
    vecs[7]  = mk(1'b0, 3'd0, 8'h00, 3'd1, 3'd5, 1'b0, 8'h22, 8'h00, 1'b1);
    vecs[8]  = mk(1'b0, 3'd0, 8'h00, 3'd1, 3'd1, 1'b1, 8'h22, 8'h22, 1'b1);
    vecs[9]  = mk(1'b0, 3'd0, 8'h00, 3'd1, 3'd3, 1'b0, 8'h11, 8'hA5, 1'b0);
    vecs[10] = mk(1'b1, 3'd2, 8'h77, 3'd2, 3'd1, 1'b1, 8'h77, 8'h11, 1'b0);
    vecs[11] = mk(1'b0, 3'd0, 8'h00, 3'd2, 3'd1, 1'b0, 8'h00, 8'h22, 1'b1);
    vecs[12] = mk(1'b0, 3'd0, 8'h00, 3'd2, 3'd0, 1'b1, 8'h00, 8'h00, 1'b1);
    vecs[13] = mk(1'b0, 3'd0, 8'h00, 3'd2, 3'd1, 1'b0, 8'h77, 8'h11, 1'b0);

    // Reset state.
    @(negedge clk);
    #2;
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_bank", a_bank, 1'b0);
    check("rst_rx", a_rx_d, 8'h00);
    check("rst_b_busy", b_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      set_a(vecs[i].we, vecs[i].wsel, vecs[i].wd, vecs[i].rx, vecs[i].ry,
            vecs[i].swap, 1'b0);
      #2;
      check($sformatf("vec%0d_rx", i), a_rx_d, vecs[i].exp_rx);
      check($sformatf("vec%0d_ry", i), a_ry_d, vecs[i].exp_ry);
      check($sformatf("vec%0d_bank", i), a_bank, vecs[i].exp_bank);
      check($sformatf("vec%0d_busy", i), a_busy, 1'b0);
    end

    // Test 3: fill bank 0 with 1..8, then clear with writes/swaps while busy.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_a(1'b1, 3'(i), 8'(i + 1), 3'd0, 3'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    set_a(1'b0, 3'd0, 8'h00, 3'd7, 3'd0, 1'b0, 1'b0);
    #2;
    check("t3_fill_r7", a_rx_d, 8'h08);
    @(negedge clk);
    set_a(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1);
    busy_cnt = 0; done_cnt = 0; done_at = 0; last_busy = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      case (k)
        1: set_a(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        2: set_a(1'b1, 3'd6, 8'hFF, 3'd6, 3'd0, 1'b1, 1'b0);
        4: set_a(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1);
        default: set_a(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
      endcase
      #2;
      if (k == 2) check("t3_no_bypass_busy", a_rx_d, 8'h07);
      if (a_busy) begin busy_cnt++; last_busy = k; end
      if (a_done) begin done_cnt++; done_at = k; end
    end
    check("t3_busy_cycles", busy_cnt, 8);
    check("t3_busy_last", last_busy, 8);
    check("t3_done_count", done_cnt, 1);
    check("t3_done_at", done_at, 9);
    check("t3_bank_kept", a_bank, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_a(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0, 1'b0);
      #2;
      check($sformatf("t3_clr_r%0d", i), a_rx_d, 8'h00);
    end
    @(negedge clk);
    set_a(1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    set_a(1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 1'b1, 1'b0);
    #2;
    check("t3_bank1_r1", a_rx_d, 8'h22);
    check("t3_bank1_sel", a_bank, 1'b1);
    @(negedge clk);
    set_a(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
    #2;
    check("t3_back_bank0", a_bank, 1'b0);

    // Test 6: clear + swap + write in the same idle cycle.
    @(negedge clk);
    set_a(1'b1, 3'd4, 8'h55, 3'd4, 3'd0, 1'b1, 1'b1);
    #2;
    check("t6_bypass", a_rx_d, 8'h55);
    @(negedge clk);
    set_a(1'b0, 3'd0, 8'h00, 3'd4, 3'd0, 1'b0, 1'b0);
    #2;
    check("t6_write_done", a_rx_d, 8'h55);
    check("t6_busy", a_busy, 1'b1);
    check("t6_bank_kept", a_bank, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      #2;
      if (a_done) seen = 1'b1;
    end
    check("t6_done_seen", seen, 1'b1);
    check("t6_r4_cleared", a_rx_d, 8'h00);
    check("t6_bank_after", a_bank, 1'b0);

    // Test 4: reset after three clear beats.
    @(negedge clk);
    set_a(1'b1, 3'd2, 8'h42, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    set_a(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    set_a(1'b1, 3'd3, 8'h33, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    set_a(1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      set_a(1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 1'b0, 1'b0);
    end
    #2;
    check("t4_busy_before", a_busy, 1'b1);
    check("t4_bank_before", a_bank, 1'b1);
    reset = 1'b1;
    #1;
    check("t4_rst_busy", a_busy, 1'b0);
    check("t4_rst_bank", a_bank, 1'b0);
    check("t4_rst_rx", a_rx_d, 8'h00);
    check("t4_rst_ry", a_ry_d, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #2;
      if (a_done) done_cnt++;
      if (a_busy) busy_cnt++;
    end
    check("t4_no_done", done_cnt, 0);
    check("t4_no_busy", busy_cnt, 0);
    @(negedge clk);
    set_a(1'b0, 3'd0, 8'h00, 3'd3, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    set_a(1'b0, 3'd0, 8'h00, 3'd3, 3'd2, 1'b0, 1'b0);
    #2;
    check("t4_bank1_r3", a_rx_d, 8'h00);

    // Test 5: zero register, 16-bit data, 16-deep clear.
    @(negedge clk);
    set_b(1'b1, 4'd0, 16'hBEEF, 4'd0, 4'd0, 1'b0);
    #2;
    check("t5_r0_wr_cycle", b_rx_d, 16'h0000);
    @(negedge clk);
    set_b(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0);
    #2;
    check("t5_r0_after", b_rx_d, 16'h0000);
    @(negedge clk);
    set_b(1'b1, 4'd15, 16'hBEEF, 4'd15, 4'd0, 1'b0);
    #2;
    check("t5_r15_bypass", b_rx_d, 16'hBEEF);
    @(negedge clk);
    set_b(1'b0, 4'd0, 16'h0000, 4'd15, 4'd15, 1'b0);
    #2;
    check("t5_r15_stored", b_ry_d, 16'hBEEF);
    @(negedge clk);
    set_b(1'b0, 4'd0, 16'h0000, 4'd15, 4'd0, 1'b1);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      set_b(1'b0, 4'd0, 16'h0000, 4'd15, 4'd0, 1'b0);
      #2;
      if (b_busy) busy_cnt++;
      if (b_done) begin done_cnt++; done_at = k; end
    end
    check("t5_busy_cycles", busy_cnt, 16);
    check("t5_done_count", done_cnt, 1);
    check("t5_done_at", done_at, 17);
    check("t5_r15_cleared", b_rx_d, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank_banked.md
Name: register_bank_banked

Overview:
- Parametrised successor to the CPU's 8x8 register bank.
- Generalised data width and depth.
- Separate write address, so a write no longer targets the rx read slot.
- Optional write-to-read bypass and optional hard-wired zero register.
- Two shadow banks swapped on request, for fast interrupt context switch.
- Sequential clear engine that zeroes the active bank.
- Sits between the decode/control unit and the ALU.

Parameters:
DATA_WIDTH, 8, width of each register
ADDR_WIDTH, 3, selector width; DEPTH = 2**ADDR_WIDTH registers per bank
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_write_en  input  1  write strobe
in_write_selector  input  ADDR_WIDTH  register written
in_write_data  input  DATA_WIDTH  write data
in_rx_selector  input  ADDR_WIDTH  read port X address
in_ry_selector  input  ADDR_WIDTH  read port Y address
out_rx_data  output  DATA_WIDTH  read port X data (combinational)
out_ry_data  output  DATA_WIDTH  read port Y data (combinational)
in_bank_swap  input  1  request to toggle the active bank
out_active_bank  output  1  currently active bank (0/1)
in_clear_req  input  1  request to zero the active bank
out_busy  output  1  high while the clear engine runs
out_clear_done  output  1  one-cycle pulse when a clear completes

Behaviour:
- Storage is two banks of DEPTH x DATA_WIDTH registers.
- Only the active bank is read, written or cleared; the other bank is held untouched.

Reset (asynchronous):
- All registers in both banks = 0.
- out_active_bank = 0; FSM = IDLE; clear counter = 0.
- out_busy = 0; out_clear_done = 0.
- Reset asserted mid-clear aborts the clear with no done pulse.

Read:
- Combinational from the active bank, zero added latency.
- BYPASS=1, with in_write_en=1, out_busy=0 and selector == in_write_selector: the port outputs in_write_data.
- Otherwise the port outputs the array contents.
- ZERO_REG=1: a selector of 0 outputs 0 regardless of bypass.

Write:
- At posedge when in_write_en=1 and FSM=IDLE: active bank[in_write_selector] <= in_write_data.
- Discarded when ZERO_REG=1 and selector = 0.
- Discarded while busy.

Bank swap:
- At posedge when in_bank_swap=1 and FSM=IDLE, with no clear request that cycle: out_active_bank toggles.
- A write in the same cycle lands in the old (pre-toggle) bank.
- Swap requests while busy are dropped, not queued.

FSM, states IDLE and CLEAR:
- IDLE, in_clear_req=1: go to CLEAR, counter <= 0.
- Clear beats swap when both are requested in the same cycle; the swap is dropped.
- A write in the same cycle as the clear request is still performed.
- CLEAR, each cycle: active bank[counter] <= 0, counter++.
- CLEAR lasts exactly DEPTH cycles; after the counter=DEPTH-1 write, go to IDLE.
- out_busy is registered and equals (state==CLEAR), high for exactly DEPTH cycles.
- out_clear_done is high for exactly the first IDLE cycle after CLEAR.
- in_clear_req during CLEAR is ignored.
- Reads during CLEAR return current array contents, partially cleared; bypass is disabled.

Widths:
- Selectors are exactly ADDR_WIDTH bits, so there is no out-of-range address.
- The counter is ADDR_WIDTH+1 bits or compares to DEPTH-1; it never wraps into a second pass.

Test Plan:
1. Defaults. Write 0xA5 to r3, then set rx=3, ry=3 the next cycle -> both ports read 0xA5. Same-cycle write 0x3C to r5 with rx=5 -> out_rx_data=0x3C combinationally (BYPASS=1) while ry=3 still reads 0xA5.
2. Bank swap. Write r1=0x11 in bank 0, swap, write r1=0x22 -> out_active_bank=1, rx=1 reads 0x22. Swap back -> rx=1 reads 0x11. Swap plus write r2=0x77 in one cycle -> 0x77 lands in the old bank.
3. Clear. Fill bank 0 with 0x01..0x08, pulse in_clear_req -> out_busy high exactly 8 cycles. out_clear_done pulses once in the cycle after. All of r0-r7 read 0. Bank 1 contents are unchanged. Writes and swaps issued while busy have no effect.
4. Reset mid-clear. Assert reset after 3 clear cycles -> immediately out_busy=0, out_active_bank=0, all reads 0. No out_clear_done pulse follows.
5. ZERO_REG=1, DATA_WIDTH=16, ADDR_WIDTH=4. Write 0xBEEF to r0 -> r0 reads 0x0000, including during the write cycle. Write 0xBEEF to r15 -> reads 0xBEEF. Clear lasts 16 cycles.
6. Simultaneous clear and swap in IDLE -> clear runs, out_active_bank is unchanged and the swap is lost. A same-cycle write of 0x55 to r4 is performed and then zeroed by the clear.
